// File: rtl/grid_pkg.sv
// Shared playfield constants and line-clear FSM state encoding.
// No logic, so no latency.
// No flow control; the renderer and game FSM import the same defaults.
package grid_pkg;

   // Default playfield geometry shared with renderer and game FSM
   localparam int GRID_COLS   = 10;
   localparam int GRID_ROWS   = 20;
   localparam int GRID_CELL_W = 3;

   // Cell value meaning "no block here"
   localparam int EMPTY_CELL  = 0;

   // Line-clear engine states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } grid_state_e;

endpackage

// File: rtl/grid_line_clear_if.sv
// Bundle of playfield access and line-clear control signals.
// No logic, so no latency.
// No flow control; busy tells the master when writes and clear requests are dropped.
interface grid_line_clear_if
   import grid_pkg::*;
#(
   parameter int COLS   = GRID_COLS,
   parameter int ROWS   = GRID_ROWS,
   parameter int CELL_W = GRID_CELL_W
);
   localparam int XW = $clog2(COLS);
   localparam int YW = $clog2(ROWS);
   localparam int CW = $clog2(ROWS + 1);

   // Shared address for both read and write
   logic [XW-1:0]     x;
   logic [YW-1:0]     y;
   // Read port
   logic              rd_en;
   logic [CELL_W-1:0] rd_data;
   // Write port
   logic              wr_en;
   logic [CELL_W-1:0] wr_data;
   // Line-clear engine control and status
   logic              clear_start;
   logic              busy;
   logic              done;
   logic [CW-1:0]     lines_cleared;

   // Game-logic side
   modport master (
      output x, y, rd_en, wr_en, wr_data, clear_start,
      input  rd_data, busy, done, lines_cleared
   );

   // Playfield store side
   modport slave (
      input  x, y, rd_en, wr_en, wr_data, clear_start,
      output rd_data, busy, done, lines_cleared
   );

endinterface

// File: rtl/grid_row_full.sv
// Flags a row in which every cell holds a nonzero value.
// Purely combinational, zero latency.
// No flow control.
module grid_row_full
   import grid_pkg::*;
#(
   parameter int COLS   = GRID_COLS,
   parameter int CELL_W = GRID_CELL_W
) (
   input  logic [COLS-1:0][CELL_W-1:0] row_dat,
   output logic                        full
);

   // AND across the row of each cell's OR-reduction
   always_comb begin
      full = 1'b1;
      for (int c = 0; c < COLS; c++) begin
         full = full & (|row_dat[c]);
      end
   end

endmodule

// File: rtl/grid_line_clear.sv
// Playfield cell store with a bottom-up full-row removal engine.
// Reads return one cycle after rd_en; a scan takes ROWS + 2k + 1 cycles for k cleared rows.
// Writes and clear requests are silently dropped while busy; no stall is applied to the master.
module grid_line_clear
   import grid_pkg::*;
#(
   parameter int COLS   = GRID_COLS,
   parameter int ROWS   = GRID_ROWS,
   parameter int CELL_W = GRID_CELL_W
) (
   input logic               clk,
   input logic               rst,
   grid_line_clear_if.slave  bus
);

   localparam int XW = $clog2(COLS);
   localparam int YW = $clog2(ROWS);
   localparam int CW = $clog2(ROWS + 1);

   // Highest legal addresses, sized to the address buses
   localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_SCAN  = SCAN;
   localparam logic [1:0] ST_SHIFT = SHIFT;
   localparam logic [1:0] ST_DONE  = DONE;

   typedef logic [COLS-1:0][CELL_W-1:0] row_t;

   row_t [ROWS-1:0]   grid_q, grid_d;
   logic [1:0]        state_q, state_d;
   logic [YW-1:0]     r_q, r_d;
   logic [CW-1:0]     lines_q, lines_d;
   logic [CELL_W-1:0] rd_data_q, rd_data_d;

   logic addr_ok;
   logic row_full;

   // Full-row detector looks at the row under the scan pointer
   grid_row_full #(
      .COLS   (COLS),
      .CELL_W (CELL_W)
   ) u_row_full (
      .row_dat (grid_q[r_q]),
      .full    (row_full)
   );

   // Address range check shared by read and write ports
   always_comb begin
      addr_ok = (bus.x <= X_LAST) && (bus.y <= Y_LAST);
   end

   // Read port: pre-edge array contents, zero when idle or out of range
   always_comb begin
      rd_data_d = CELL_W'(EMPTY_CELL);
      if (bus.rd_en && addr_ok) begin
         rd_data_d = grid_q[bus.y][bus.x];
      end
   end

   // Line-clear FSM, array updates, row pointer and cleared-row counter
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      lines_d = lines_q;
      grid_d  = grid_q;

      case (state_q)
         ST_IDLE: begin
            // A write in the same cycle as clear_start lands first, so the scan sees it
            if (bus.wr_en && addr_ok) begin
               grid_d[bus.y][bus.x] = bus.wr_data;
            end
            if (bus.clear_start) begin
               r_d     = Y_LAST;
               lines_d = '0;
               state_d = ST_SCAN;
            end
         end

         ST_SCAN: begin
            if (row_full) begin
               state_d = ST_SHIFT;
            end else if (r_q != '0) begin
               r_d = r_q - YW'(1);
            end else begin
               state_d = ST_DONE;
            end
         end

         ST_SHIFT: begin
            // Everything above the full row drops by one; pointer stays put so a
            // stacked full row that just moved down gets re-checked
            for (int i = 1; i < ROWS; i++) begin
               if (YW'(i) <= r_q) begin
                  grid_d[i] = grid_q[i-1];
               end
            end
            for (int c = 0; c < COLS; c++) begin
               grid_d[0][c] = CELL_W'(EMPTY_CELL);
            end
            lines_d = lines_q + CW'(1);
            state_d = ST_SCAN;
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset that also wipes the playfield
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         r_q       <= '0;
         lines_q   <= '0;
         rd_data_q <= '0;
         grid_q    <= '0;
      end else begin
         state_q   <= state_d;
         r_q       <= r_d;
         lines_q   <= lines_d;
         rd_data_q <= rd_data_d;
         grid_q    <= grid_d;
      end
   end

   // Status outputs decoded from registered state
   always_comb begin
      bus.rd_data       = rd_data_q;
      bus.busy          = (state_q != ST_IDLE);
      bus.done          = (state_q == ST_DONE);
      bus.lines_cleared = lines_q;
   end

endmodule

// File: doc/grid_line_clear.md
# grid_line_clear

Parametrised playfield store for the arcade games: a ROWS x COLS array of multi-bit cells (0 = empty, nonzero = colour/piece id) with a synchronous read port, a write port, and a built-in line-clear engine. On request it scans bottom-to-top, removes every completely filled row, collapses the rows above it downward and reports how many lines were cleared. It sits between the game-logic FSM (piece placement, collision reads) and the VGA renderer/score logic.

## Interface
- COLS, default 10: cells per row (x range 0..COLS-1)
- ROWS, default 20: rows (y range 0..ROWS-1, row 0 = top)
- CELL_W, default 3: bits per cell; value 0 means empty
- XW = $clog2(COLS), YW = $clog2(ROWS), CW = $clog2(ROWS+1): derived localparams

- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- x  in  XW  column address (read and write)
- y  in  YW  row address (read and write)
- rd_en  in  1  read request
- rd_data  out  CELL_W  registered read data
- wr_en  in  1  write request
- wr_data  in  CELL_W  value written to cell (y,x)
- clear_start  in  1  start line-clear scan (single-cycle pulse)
- busy  out  1  line-clear engine active
- done  out  1  one-cycle pulse, scan finished
- lines_cleared  out  CW  rows removed by the last scan

## Operation
- Reset (rst=1 at edge): every cell 0, FSM IDLE, rd_data 0, busy 0, done 0, lines_cleared 0.
- Read: rd_en=1 with in-range (y,x) -> rd_data = cell at next edge; rd_en=0 or out-of-range -> rd_data = 0 at next edge. Reads are legal in any state and reflect the array contents before that edge.
- Write: wr_en=1, FSM IDLE, in-range address -> cell(y,x) <= wr_data. Out-of-range or busy -> write dropped, no other side effect.
- FSM states: IDLE, SCAN, SHIFT, DONE.
  - IDLE: clear_start=1 -> row pointer r <= ROWS-1, lines_cleared <= 0, go SCAN.
  - SCAN: row r full (all COLS cells nonzero) -> SHIFT. Not full and r>0 -> r <= r-1, stay SCAN. Not full and r=0 -> DONE.
  - SHIFT: in one cycle row i <= row i-1 for all i in 1..r, row 0 <= all zero, lines_cleared +1; r unchanged; go SCAN (re-check same row, handles stacked full rows).
  - DONE: done=1 for this cycle only; go IDLE.
- busy = 1 in SCAN, SHIFT, DONE; 0 in IDLE.
- clear_start while busy: ignored. lines_cleared holds its value from DONE until the next accepted clear_start.
- Empty row 0 always terminates; a full row 0 is cleared by SHIFT (becomes zero) then rescanned as not full -> DONE.

## Timing
- Read latency: 1 cycle.
- Write visible to a read issued the following cycle.
- clear_start accepted at edge 0; busy high from cycle 1.
- With k rows cleared: SCAN cycles = ROWS + k, SHIFT cycles = k; done high in cycle ROWS + 2k + 1; busy low from cycle ROWS + 2k + 2.
- wr_en and clear_start in same IDLE cycle: write lands at that edge, scan sees the written value.
- rst mid-scan: synchronous abort to reset state at that edge; no done pulse; partially shifted array is cleared to zero.

## Structure
- Package grid_pkg: FSM state enum (IDLE, SCAN, SHIFT, DONE), EMPTY_CELL constant (0), default COLS/ROWS/CELL_W constants shared with renderer and game FSM.
- Sub-module grid_row_full: combinational, COLS x CELL_W row in, 1-bit full out (AND of per-cell OR-reductions); instantiated once on the row selected by r.
- Array, pointer, counter and FSM in grid_line_clear.

## Test plan
- Reset then read all 200 cells (defaults) -> rd_data = 0 every time, busy = 0, lines_cleared = 0.
- Write 3'd5 to (y=7,x=4), read same next cycle -> rd_data = 5 one cycle after rd_en; read x=10 -> 0; write y=20 -> array unchanged.
- Fill row 19 with nonzero, row 18 with one gap, mark (18,0)=2; clear_start -> done at cycle 23, lines_cleared = 1, former row 18 now in row 19, row 0 empty.
- Fill rows 16..19 (4 rows), clear_start -> done at cycle 29, lines_cleared = 4, rows 16..19 hold former rows 12..15; wr_en during busy leaves array unchanged.
- Assert rst at cycle 5 of a scan -> next cycle busy = 0, done never pulses, all cells 0; clear_start while busy has no effect on lines_cleared or timing.
